// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one external combinational ALU between two
// requesters, holds operands for a settle window, and returns a tagged response.
module alu_arbiter #(
  parameter int unsigned ADD_CYC = 1,
  parameter int unsigned MUL_CYC = 2,
  parameter int unsigned CW      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  input  logic [7:0]  req_a0,
  input  logic [7:0]  req_a1,
  input  logic [7:0]  req_b0,
  input  logic [7:0]  req_b1,
  input  logic        req_c0,
  input  logic        req_c1,
  output logic [1:0]  alu_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_c,
  input  logic [15:0] alu_out,
  input  logic        alu_flag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic        resp_flag,
  output logic        resp_err
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpIll = 2'b11;

  localparam logic [CW-1:0] AddLast = CW'(ADD_CYC - 1);
  localparam logic [CW-1:0] MulLast = CW'(MUL_CYC - 1);

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic          c_q, c_d;
  logic          id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic [15:0]   data_q, data_d;
  logic          flag_q, flag_d;
  logic          err_q, err_d;

  logic          grant_vld;
  logic          grant_id;
  logic [1:0]    sel_op;
  logic [7:0]    sel_a;
  logic [7:0]    sel_b;
  logic          sel_c;
  logic [CW-1:0] exec_last;

  // Grant only in IDLE; gated by rst_n so no accept strobe leaks out during reset.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == StIdle && rst_n) begin
      unique case (req_valid)
        2'b01: begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end
        2'b10: begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        2'b11: begin
          grant_vld = 1'b1;
          grant_id  = ~last_grant_q;
        end
        default: begin
          grant_vld = 1'b0;
          grant_id  = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = {grant_vld & grant_id, grant_vld & ~grant_id};

  always_comb begin
    sel_op = grant_id ? req_op1 : req_op0;
    sel_a  = grant_id ? req_a1  : req_a0;
    sel_b  = grant_id ? req_b1  : req_b0;
    sel_c  = grant_id ? req_c1  : req_c0;
  end

  assign exec_last = (op_q == OpMul) ? MulLast : AddLast;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    flag_d       = flag_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          op_d         = sel_op;
          a_d          = sel_a;
          b_d          = sel_b;
          c_d          = sel_c;
          id_d         = grant_id;
          last_grant_d = grant_id;
          cnt_d        = '0;
          if (sel_op == OpIll) begin
            // Illegal op never touches the ALU; respond next cycle with a zeroed error.
            data_d  = '0;
            flag_d  = 1'b0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == exec_last) begin
          data_d  = (op_q == OpMul) ? alu_out : {8'h00, alu_out[7:0]};
          flag_d  = alu_flag;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= 1'b0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      flag_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      flag_q       <= flag_d;
      err_q        <= err_d;
    end
  end

  // ALU inputs are quiet (all zero) outside the settle window.
  always_comb begin
    alu_sel = '0;
    alu_a   = '0;
    alu_b   = '0;
    alu_c   = 1'b0;
    if (state_q == StExec) begin
      alu_sel = op_q;
      alu_a   = a_q;
      alu_b   = b_q;
      alu_c   = c_q;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_flag  = flag_q;
  assign resp_err   = err_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    req_ready != 2'b11);

  a_no_ill_sel: assert property (@(posedge clk) disable iff (!rst_n)
    alu_sel != OpIll);

  a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid && !resp_ready |=> resp_valid &&
      $stable({resp_id, resp_data, resp_flag, resp_err}));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with a settling ALU model that returns
// garbage until its inputs have been stable for the op's required cycle count.
module tb_alu_arbiter;

  localparam int unsigned ADD_CYC = 1;
  localparam int unsigned MUL_CYC = 2;
  localparam int unsigned CW      = 3;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    int         gap;
    bit         abandon;
    bit         scramble;
  } stim_t;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic [15:0] data;
    logic        flag;
    logic        err;
    int          t;
    int          n;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [7:0]  req_a0, req_a1, req_b0, req_b1;
  logic        req_c0, req_c1;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_a, alu_b;
  logic        alu_c;
  logic [15:0] alu_out;
  logic        alu_flag;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_data;
  logic        resp_flag;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  stim_t pend[2][$];
  exp_t  sb[$];
  exp_t  act;
  exp_t  cur;
  bit    busy = 1'b0;
  bit    have_cur = 1'b0;
  bit    last_grant = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(
    .ADD_CYC (ADD_CYC),
    .MUL_CYC (MUL_CYC),
    .CW      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .req_c0     (req_c0),
    .req_c1     (req_c1),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_out    (alu_out),
    .alu_flag   (alu_flag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_flag  (resp_flag),
    .resp_err   (resp_err)
  );

  // ALU model: correct output only after inputs have held for the op's settle time.
  logic [18:0] alu_in, alu_in_prev;
  int          alu_age, alu_settle, alu_need;
  logic [8:0]  s9;
  logic [15:0] p16;

  assign alu_in = {alu_sel, alu_a, alu_b, alu_c};

  always @(posedge clk) begin
    alu_in_prev <= alu_in;
    alu_age     <= alu_settle;
  end

  always_comb begin
    alu_settle = (alu_in == alu_in_prev) ? ((alu_age < 1000) ? alu_age + 1 : alu_age) : 0;
    alu_need   = (alu_sel == 2'b10) ? int'(MUL_CYC) : int'(ADD_CYC);
    s9         = '0;
    p16        = '0;
    alu_out    = 16'hBAD0;
    alu_flag   = 1'b1;
    case (alu_sel)
      2'b00: begin
        s9       = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_c};
        alu_out  = {8'hA5, s9[7:0]};
        alu_flag = s9[8];
      end
      2'b01: begin
        s9       = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_c};
        alu_out  = {8'h5A, s9[7:0]};
        alu_flag = s9[8];
      end
      2'b10: begin
        p16      = alu_a * alu_b;
        alu_out  = p16;
        alu_flag = |p16[15:8];
      end
      default: begin
        alu_out  = 16'hBAD0;
        alu_flag = 1'b1;
      end
    endcase
    if (alu_settle < alu_need - 1) begin
      alu_out  = 16'hDEAD;
      alu_flag = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: response computed from the op's arithmetic meaning.
  function automatic exp_t model(input logic id, input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic c, input int t);
    exp_t e;
    int   s;
    e.id = id; e.op = op; e.a = a; e.b = b; e.c = c; e.t = t;
    e.data = '0; e.flag = 1'b0; e.err = 1'b0; e.n = 0;
    case (op)
      2'b00: begin
        s = int'(a) + int'(b) + int'(c);
        e.data = 16'(s % 256); e.flag = (s > 255); e.n = ADD_CYC;
      end
      2'b01: begin
        s = int'(a) - int'(b) - int'(c);
        e.data = 16'((s + 256) % 256); e.flag = (s < 0); e.n = ADD_CYC;
      end
      2'b10: begin
        s = int'(a) * int'(b);
        e.data = 16'(s); e.flag = (s > 255); e.n = MUL_CYC;
      end
      default: e.err = 1'b1;
    endcase
    e.due = t + 1 + e.n;
    return e;
  endfunction

  // Per-requester drivers: hold a request until accepted (or abandoned).
  for (genvar g = 0; g < 2; g++) begin : g_drv
    logic       v;
    logic [1:0] op;
    logic [7:0] a, b;
    logic       c;
    logic       acc;
    int         idx, waited, gap_cnt;
    initial begin
      v = 1'b0; op = '0; a = '0; b = '0; c = 1'b0; acc = 1'b0;
      idx = 0; waited = 0; gap_cnt = 0;
      forever begin
        @(negedge clk);
        acc = req_ready[g];
        @(posedge clk);
        #1;
        if (v) begin
          if (acc) begin
            v = 1'b0;
            idx++;
          end else begin
            waited++;
            if (pend[g][idx].abandon && waited >= 3) begin
              v = 1'b0;
              idx++;
            end else if (pend[g][idx].scramble) begin
              a = 8'($urandom);
              b = 8'($urandom);
            end
          end
        end
        if (!v && idx < pend[g].size()) begin
          if (gap_cnt < pend[g][idx].gap) begin
            gap_cnt++;
          end else begin
            gap_cnt = 0; waited = 0; v = 1'b1;
            op = pend[g][idx].op; a = pend[g][idx].a; b = pend[g][idx].b; c = pend[g][idx].c;
          end
        end
      end
    end
  end

  assign req_valid = {g_drv[1].v, g_drv[0].v};
  assign req_op0 = g_drv[0].op;
  assign req_a0  = g_drv[0].a;
  assign req_b0  = g_drv[0].b;
  assign req_c0  = g_drv[0].c;
  assign req_op1 = g_drv[1].op;
  assign req_a1  = g_drv[1].a;
  assign req_b1  = g_drv[1].b;
  assign req_c1  = g_drv[1].c;

  // Monitor: arbitration prediction, ALU drive window, and response scoreboard.
  always @(negedge clk) begin
    logic [1:0]  exp_rdy;
    logic [18:0] exp_alu;
    bit          in_exec;
    logic        gid;
    if (!rst_n) begin
      sb.delete();
      busy = 1'b0;
      have_cur = 1'b0;
      last_grant = 1'b1;
    end else begin
      in_exec = busy && !act.err && (cyc > act.t) && (cyc <= act.t + act.n);
      exp_alu = in_exec ? {act.op, act.a, act.b, act.c} : '0;
      check("alu_drive", alu_in, exp_alu);

      exp_rdy = 2'b00;
      if (!busy) begin
        case (req_valid)
          2'b01:   exp_rdy = 2'b01;
          2'b10:   exp_rdy = 2'b10;
          2'b11:   exp_rdy = last_grant ? 2'b01 : 2'b10;
          default: exp_rdy = 2'b00;
        endcase
      end
      check("req_ready", req_ready, exp_rdy);
      if (exp_rdy != 2'b00) begin
        gid = exp_rdy[1];
        act = gid ? model(1'b1, req_op1, req_a1, req_b1, req_c1, cyc)
                  : model(1'b0, req_op0, req_a0, req_b0, req_c0, cyc);
        sb.push_back(act);
        last_grant = gid;
        busy = 1'b1;
      end

      if (have_cur) check("resp_held", resp_valid, 1'b1);
      if (resp_valid) begin
        if (!have_cur) begin
          check("resp_expected", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            check("resp_latency", cyc, cur.due);
          end
        end
        if (have_cur) begin
          check("resp_fields", {resp_id, resp_data, resp_flag, resp_err},
                {cur.id, cur.data, cur.flag, cur.err});
          if (resp_ready) begin
            have_cur = 1'b0;
            busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic push(input int g, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic c);
    stim_t s;
    s.op = op; s.a = a; s.b = b; s.c = c; s.gap = 0; s.abandon = 0; s.scramble = 0;
    pend[g].push_back(s);
  endtask

  function automatic bit all_done();
    return g_drv[0].idx == pend[0].size() && g_drv[1].idx == pend[1].size() &&
           !g_drv[0].v && !g_drv[1].v && !busy && !have_cur && sb.size() == 0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (k < budget && !all_done()) begin
      @(posedge clk);
      k++;
    end
    check(name, k < budget, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {req_ready, alu_in, resp_valid, resp_id, resp_data, resp_flag,
                            resp_err}, '0);
    #2 rst_n = 1'b1;

    // Reset in the middle of a multiply: no response may follow.
    @(posedge clk);
    push(0, 2'b10, 8'hFF, 8'hFF, 1'b0);
    for (int k = 0; k < 20 && g_drv[0].idx < 1; k++) @(posedge clk);
    check("t1_accept", g_drv[0].idx, 1);
    #3 rst_n = 1'b0;
    #1;
    check("reset_mid_exec", {req_ready, alu_in, resp_valid, resp_id, resp_data, resp_flag,
                             resp_err}, '0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    push(0, 2'b00, 8'h10, 8'h20, 1'b0);
    wait_idle("t1_idle", 50);

    push(1, 2'b00, 8'hFF, 8'h01, 1'b1);
    wait_idle("t2_idle", 50);

    push(0, 2'b10, 8'hFF, 8'hFF, 1'b0);
    push(0, 2'b01, 8'h05, 8'h07, 1'b0);
    wait_idle("t3_idle", 50);

    for (int i = 0; i < 3; i++) begin
      push(0, 2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'($urandom));
      push(1, 2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    wait_idle("t4_idle", 100);

    resp_ready = 1'b0;
    push(0, 2'b00, 8'h33, 8'h44, 1'b1);
    push(1, 2'b01, 8'h10, 8'h80, 1'b0);
    repeat (8) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_idle("t5_idle", 50);

    push(1, 2'b11, 8'h12, 8'h34, 1'b1);
    wait_idle("t6_idle", 50);

    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 40; i++) begin
        s.op       = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        s.a        = 8'($urandom);
        s.b        = 8'($urandom);
        s.c        = 1'($urandom);
        s.gap      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        s.abandon  = ($urandom_range(0, 9) == 0);
        s.scramble = ($urandom_range(0, 4) == 0);
        pend[g].push_back(s);
      end
    end
    for (int k = 0; k < 3000 && !all_done(); k++) begin
      @(posedge clk);
      #2 resp_ready = ($urandom_range(0, 3) != 0);
    end
    resp_ready = 1'b1;
    wait_idle("random_idle", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
